vga_timing_counter: RTL



---
 rtl/vga_timing_counter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/vga_timing_counter.sv
// ---------------------------------------------------------------------------
// vga_timing_counter
//
// Pixel/line/frame timing generator for the 640x480@60 VGA pipeline.
// Divides the system clock down to the pixel rate, walks the horizontal and
// vertical counters across the full raster (including blanking), decodes
// vertical sync and the visible-area flag, and emits the line-end,
// frame-start and Game-of-Life generation ticks.
//
// Ports
//   clk          system clock; every register updates on its rising edge
//   reset        synchronous, active-high; wins over enable and all events
//   enable       run (1) / freeze (0) of all timing state
//   pixelTick    one-clk pulse at pixel rate
//   hCount       current pixel column, 0..H_TOTAL-1
//   vCount       current line, 0..V_TOTAL-1
//   vSync        vertical sync, active low
//   videoActive  high while hCount < H_ACTIVE and vCount < V_ACTIVE
//   lineEnd      one-clk pulse on the last pixel of each line
//   frameStart   one-clk pulse in the cycle before the counters wrap to (0,0)
//   genTick      one-clk pulse every FRAMES_PER_GEN frames, with frameStart
//
// All pulse outputs and the sync/active decodes are combinational from the
// registered counters, so they are valid in the same cycle as the counts
// they describe and hold steady between pixel ticks.
// ---------------------------------------------------------------------------
module vga_timing_counter #(
   parameter int CLK_DIV        = 4,
   parameter int H_ACTIVE       = 640,
   parameter int H_TOTAL        = 800,
   parameter int V_ACTIVE       = 480,
   parameter int V_FRONT_PORCH  = 10,
   parameter int V_SYNC_PULSE   = 2,
   parameter int V_TOTAL        = 525,
   parameter int FRAMES_PER_GEN = 30
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       enable,
   output logic                       pixelTick,
   output logic [$clog2(H_TOTAL)-1:0] hCount,
   output logic [$clog2(V_TOTAL)-1:0] vCount,
   output logic                       vSync,
   output logic                       videoActive,
   output logic                       lineEnd,
   output logic                       frameStart,
   output logic                       genTick
);

   localparam int H_W   = $clog2(H_TOTAL);
   localparam int V_W   = $clog2(V_TOTAL);
   // Divider and frame counters keep at least one bit so that the
   // degenerate settings CLK_DIV=1 / FRAMES_PER_GEN=1 still elaborate.
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int FRM_W = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [H_W-1:0]   H_LAST   = H_W'(H_TOTAL - 1);
   localparam logic [V_W-1:0]   V_LAST   = V_W'(V_TOTAL - 1);
   localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FRAMES_PER_GEN - 1);

   // Region bounds carry one extra bit: an active or sync boundary may sit
   // exactly at TOTAL, which need not fit in the counter width itself.
   localparam logic [H_W:0] H_ACT  = (H_W + 1)'(H_ACTIVE);
   localparam logic [V_W:0] V_ACT  = (V_W + 1)'(V_ACTIVE);
   localparam logic [V_W:0] VS_BEG = (V_W + 1)'(V_ACTIVE + V_FRONT_PORCH);
   localparam logic [V_W:0] VS_END = (V_W + 1)'(V_ACTIVE + V_FRONT_PORCH + V_SYNC_PULSE);

   logic [DIV_W-1:0] divcnt;
   logic [FRM_W-1:0] framecnt;

   logic div_last;
   logic h_last;
   logic v_last;
   logic frm_last;
   logic in_vsync;
   logic h_visible;
   logic v_visible;

   // ---- decode stage: combinational from registered counters ----
   always_comb begin
      div_last  = (divcnt   == DIV_LAST);
      h_last    = (hCount   == H_LAST);
      v_last    = (vCount   == V_LAST);
      frm_last  = (framecnt == FRM_LAST);

      // Pulses are forced low while reset is asserted so that a reset landing
      // on the final pixel of a frame never leaks a frameStart/genTick.
      pixelTick  = enable & ~reset & div_last;
      lineEnd    = pixelTick & h_last;
      frameStart = lineEnd & v_last;
      genTick    = frameStart & frm_last;

      h_visible   = ({1'b0, hCount} < H_ACT);
      v_visible   = ({1'b0, vCount} < V_ACT);
      videoActive = h_visible & v_visible;

      in_vsync = ({1'b0, vCount} >= VS_BEG) && ({1'b0, vCount} < VS_END);
      vSync    = ~in_vsync;
   end

   // ---- state stage: divider, raster counters, frame counter ----
   always_ff @(posedge clk) begin
      if (reset) begin
         divcnt   <= '0;
         hCount   <= '0;
         vCount   <= '0;
         framecnt <= '0;
      end else if (enable) begin
         divcnt <= div_last ? '0 : divcnt + 1'b1;

         if (pixelTick) begin
            if (h_last) begin
               hCount <= '0;
               vCount <= v_last ? '0 : vCount + 1'b1;
            end else begin
               hCount <= hCount + 1'b1;
            end
         end

         if (frameStart) begin
            framecnt <= frm_last ? '0 : framecnt + 1'b1;
         end
      end
   end

endmodule
